// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Shares one single-port word memory (Memory_unit) between two requesters,
//   A and B.  After reset every word is zero-filled; then each granted access
//   runs a setup cycle (fields driven, select low), one strobe cycle (select
//   high) and a completion cycle (ack pulse, read data captured).  Ties
//   between A and B alternate round-robin, starting with A.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_x, we_x, addr_x,     requester x (a/b): request held with stable
//   wdata_x                  fields until ack_x; we_x=1 write, 0 read
//   ack_a, ack_b             one-cycle completion pulses
//   rdata                    read data, valid in the ack cycle, held until
//                            the next read completes
//   init_done                high once the zero-fill has finished
//   mem_op, mem_select,      memory control, address and write data
//   mem_address, mem_in_bus  (all registered)
//   mem_out_bus              memory read data
// ---------------------------------------------------------------------------
module memory_arbiter #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 3,
   parameter int NUM_WORDS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_a,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata,
   output logic              init_done,
   output logic              mem_op,
   output logic              mem_select,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in_bus,
   input  logic [DATA_W-1:0] mem_out_bus
);

   typedef enum logic [2:0] {
      INIT_SETUP,
      INIT_STROBE,
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;   // 1 = B served last
   logic              gnt_b_q, gnt_b_d;             // 1 = B owns the access
   logic              init_done_q, init_done_d;
   logic              mem_op_q, mem_op_d;
   logic              mem_select_q, mem_select_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_in_bus_q, mem_in_bus_d;
   logic              ack_a_q, ack_a_d;
   logic              ack_b_q, ack_b_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              pick_b;

   // Next-state and next-output logic.  Every output is a flop, so the
   // values computed here are what the memory sees in the following cycle.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_grant_d  = last_grant_q;
      gnt_b_d       = gnt_b_q;
      init_done_d   = init_done_q;
      mem_op_d      = mem_op_q;
      mem_select_d  = 1'b0;
      mem_address_d = mem_address_q;
      mem_in_bus_d  = mem_in_bus_q;
      ack_a_d       = 1'b0;
      ack_b_d       = 1'b0;
      rdata_d       = rdata_q;
      pick_b        = 1'b0;

      unique case (state_q)
         INIT_SETUP: begin
            // Drive a zero write to word cnt and raise the strobe next cycle.
            mem_op_d      = 1'b1;
            mem_address_d = cnt_q;
            mem_in_bus_d  = '0;
            mem_select_d  = 1'b1;
            state_d       = INIT_STROBE;
         end

         INIT_STROBE: begin
            if (cnt_q == LAST_WORD) begin
               init_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d         = cnt_q + ADDR_W'(1);
               mem_address_d = cnt_q + ADDR_W'(1);
               state_d       = INIT_SETUP;
            end
         end

         IDLE: begin
            if (req_a || req_b) begin
               // B wins when it is alone, or on a tie when A was served last.
               pick_b        = req_b && (!req_a || !last_grant_q);
               gnt_b_d       = pick_b;
               last_grant_d  = pick_b;
               mem_op_d      = pick_b ? we_b    : we_a;
               mem_address_d = pick_b ? addr_b  : addr_a;
               mem_in_bus_d  = pick_b ? wdata_b : wdata_a;
               state_d       = SETUP;
            end
         end

         SETUP: begin
            mem_select_d = 1'b1;
            state_d      = ACCESS;
         end

         ACCESS: begin
            // Strobe is high this cycle, so out_bus holds the addressed word.
            ack_a_d = !gnt_b_q;
            ack_b_d = gnt_b_q;
            if (!mem_op_q) begin
               rdata_d = mem_out_bus;
            end
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = INIT_SETUP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= INIT_SETUP;
         cnt_q         <= '0;
         last_grant_q  <= 1'b1;
         gnt_b_q       <= 1'b0;
         init_done_q   <= 1'b0;
         mem_op_q      <= 1'b0;
         mem_select_q  <= 1'b0;
         mem_address_q <= '0;
         mem_in_bus_q  <= '0;
         ack_a_q       <= 1'b0;
         ack_b_q       <= 1'b0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_grant_q  <= last_grant_d;
         gnt_b_q       <= gnt_b_d;
         init_done_q   <= init_done_d;
         mem_op_q      <= mem_op_d;
         mem_select_q  <= mem_select_d;
         mem_address_q <= mem_address_d;
         mem_in_bus_q  <= mem_in_bus_d;
         ack_a_q       <= ack_a_d;
         ack_b_q       <= ack_b_d;
         rdata_q       <= rdata_d;
      end
   end

   assign ack_a       = ack_a_q;
   assign ack_b       = ack_b_q;
   assign rdata       = rdata_q;
   assign init_done   = init_done_q;
   assign mem_op      = mem_op_q;
   assign mem_select  = mem_select_q;
   assign mem_address = mem_address_q;
   assign mem_in_bus  = mem_in_bus_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//   Bench for memory_arbiter with a behavioural 8x8 memory attached.
//   Completions are tracked with an expectation queue; sequential traffic
//   comes from a vector table, multi-cycle corner cases are hand-written.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 3;
   localparam int NUM_WORDS = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_a, we_a, req_b, we_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] wdata_a, wdata_b;
   logic              ack_a, ack_b, init_done;
   logic [DATA_W-1:0] rdata;
   logic              mem_op, mem_select;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_in_bus, mem_out_bus;

   always #5 clk = ~clk;

   memory_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)
   ) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .init_done(init_done),
      .mem_op(mem_op), .mem_select(mem_select), .mem_address(mem_address),
      .mem_in_bus(mem_in_bus), .mem_out_bus(mem_out_bus)
   );

   // Memory_unit model: write on a strobed edge, asynchronous read.
   logic [DATA_W-1:0] stored_value [NUM_WORDS];
   always @(posedge clk) begin
      if (mem_select && mem_op) stored_value[mem_address] <= mem_in_bus;
   end
   assign mem_out_bus = stored_value[mem_address];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit                is_b;
      logic [DATA_W-1:0] rdata;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   typedef struct {
      bit                is_b;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;   // rdata expected in the ack cycle
   } vec_t;
   vec_t vecs[5];

   // Completion scoreboard and strobe-field stability monitor.
   logic              prev_sel;
   logic [ADDR_W+DATA_W:0] prev_fields;
   always @(negedge clk) begin
      if (ack_a || ack_b) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ack", {30'd0, ack_a, ack_b}, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("ack_who", {30'd0, ack_a, ack_b}, mon_e.is_b ? 32'd1 : 32'd2);
            check("ack_rdata", {24'd0, rdata}, {24'd0, mon_e.rdata});
         end
      end
      if (mem_select && init_done) begin
         check("select_one_cycle", {31'd0, prev_sel}, 32'd0);
         check("fields_stable", {20'd0, mem_op, mem_address, mem_in_bus}, {20'd0, prev_fields});
      end
      prev_sel    <= mem_select;
      prev_fields <= {mem_op, mem_address, mem_in_bus};
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_outputs",
            {8'd0, ack_a, ack_b, init_done, mem_op, mem_select, mem_address, mem_in_bus, rdata},
            32'd0);
      rst = 1'b0;
   endtask

   // One isolated transaction issued from IDLE; hold is the rdata value
   // that must persist until the ack cycle.
   task automatic run_txn(input vec_t v, input logic [DATA_W-1:0] hold);
      logic [2:0] sel_pat;
      bit got, moved;
      int lat;
      @(negedge clk);
      if (v.is_b) begin
         req_b = 1'b1; we_b = v.we; addr_b = v.addr; wdata_b = v.wdata;
      end else begin
         req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
      end
      sb_q.push_back('{is_b: v.is_b, rdata: v.exp_rdata});
      sel_pat = '0; got = 0; moved = 0; lat = 0;
      for (int w = 1; w <= 20; w++) begin
         @(negedge clk);
         if (w <= 3) sel_pat[w-1] = mem_select;
         if (v.is_b ? ack_b : ack_a) begin
            got = 1; lat = w;
            req_a = 1'b0; req_b = 1'b0;
            break;
         end
         if (rdata !== hold) moved = 1;
      end
      if (!got) begin
         check("ack_timeout", 32'd0, 32'd1);
         req_a = 1'b0; req_b = 1'b0;
      end else begin
         check("latency", lat, 32'd3);
         check("select_pattern", {29'd0, sel_pat}, 32'd2);
         check("rdata_held_before_ack", {31'd0, moved}, 32'd0);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int sel_cnt;
      int n;
      int times[4];
      bit got;
      logic [DATA_W-1:0] hold;

      rst = 1'b0;
      req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
      req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
      for (int i = 0; i < NUM_WORDS; i++) stored_value[i] = 8'hA0 + 8'(i);

      // ---- 1: reset and zero-fill -------------------------------------
      do_reset();
      sel_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (mem_select) begin
            check("init_addr", {29'd0, mem_address}, sel_cnt);
            check("init_op_data", {23'd0, mem_op, mem_in_bus}, 32'h100);
            sel_cnt++;
         end
         if (c == 15) check("init_done_early", {31'd0, init_done}, 32'd0);
      end
      check("init_done_c16", {31'd0, init_done}, 32'd1);
      check("init_pulses", sel_cnt, 32'd8);
      for (int i = 0; i < NUM_WORDS; i++)
         check("zero_fill", {24'd0, stored_value[i]}, 32'd0);

      // ---- 2 and 6: sequential traffic from the vector table ------------
      vecs[0] = '{is_b: 0, we: 1, addr: 3'd0, wdata: 8'h55, exp_rdata: 8'h00};
      vecs[1] = '{is_b: 0, we: 0, addr: 3'd0, wdata: 8'h00, exp_rdata: 8'h55};
      vecs[2] = '{is_b: 0, we: 1, addr: 3'd1, wdata: 8'h33, exp_rdata: 8'h55};
      vecs[3] = '{is_b: 1, we: 0, addr: 3'd7, wdata: 8'h00, exp_rdata: 8'h00};
      vecs[4] = '{is_b: 1, we: 0, addr: 3'd1, wdata: 8'h00, exp_rdata: 8'h33};
      hold = 8'h00;
      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i], hold);
         hold = vecs[i].exp_rdata;
      end

      // ---- 3: both requesting continuously, B was served last ------------
      @(negedge clk);
      req_a = 1; we_a = 1; addr_a = 3'd4; wdata_a = 8'hF0;
      req_b = 1; we_b = 0; addr_b = 3'd4; wdata_b = 8'h00;
      sb_q.push_back('{is_b: 0, rdata: 8'h33});
      sb_q.push_back('{is_b: 1, rdata: 8'hF0});
      sb_q.push_back('{is_b: 0, rdata: 8'hF0});
      sb_q.push_back('{is_b: 1, rdata: 8'hF0});
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (ack_a || ack_b) begin
            times[n] = c;
            n++;
            if (n == 4) begin
               req_a = 0; req_b = 0;
               break;
            end
         end
      end
      req_a = 0; req_b = 0;
      check("rr_ack_count", n, 32'd4);
      if (n == 4) begin
         check("rr_first_latency", times[0], 32'd3);
         for (int i = 1; i < 4; i++) check("rr_spacing", times[i] - times[i-1], 32'd4);
      end

      // ---- 4: write requested during zero-fill --------------------------
      do_reset();
      got = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 2) begin
            req_a = 1; we_a = 1; addr_a = 3'd5; wdata_a = 8'h77;
            sb_q.push_back('{is_b: 0, rdata: 8'h00});
         end
         if (ack_a) begin
            got = 1;
            check("init_req_ack_cycle", c, 32'd19);
            check("init_req_after_done", {31'd0, init_done}, 32'd1);
            req_a = 0;
            break;
         end
      end
      req_a = 0;
      check("init_req_acked", {31'd0, got}, 32'd1);
      check("init_req_word", {24'd0, stored_value[5]}, 32'h77);

      // ---- 5: reset during the strobe of a B write -----------------------
      @(negedge clk);
      req_b = 1; we_b = 1; addr_b = 3'd2; wdata_b = 8'hAA;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_access", {31'd0, mem_select}, 32'd1);
      rst = 1; req_b = 0;
      @(negedge clk);
      check("abort_reset_outputs", {29'd0, ack_b, mem_select, init_done}, 32'd0);
      rst = 0;
      got = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (ack_b) got = 1;
      end
      check("abort_no_ack", {31'd0, got}, 32'd0);
      check("abort_reinit_done", {31'd0, init_done}, 32'd1);
      check("abort_word_zero", {24'd0, stored_value[2]}, 32'd0);
      run_txn('{is_b: 1, we: 0, addr: 3'd2, wdata: 8'h00, exp_rdata: 8'h00}, 8'h00);

      @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
